// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - slot-framed single-port VRAM arbiter between the video fetch engine and the Z80 CPU
module vram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int SLOT_LEN  = 8,
    parameter int VID_PHASE = 0,
    parameter int CPU_PHASE = 4
) (
    input  logic              F14M,
    input  logic              RESET_N,
    input  logic              vid_sync,
    input  logic              vid_blank,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int PH_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [PH_W-1:0] VID_PH     = PH_W'(VID_PHASE);
    localparam logic [PH_W-1:0] CPU_PH     = PH_W'(CPU_PHASE);
    localparam logic [PH_W-1:0] GUARD_FROM = PH_W'(SLOT_LEN - 2);

    typedef enum logic [2:0] {IDLE, VID_RD, VID_CAP, CPU_ACC, CPU_CAP} state_t;

    state_t          state;
    state_t          state_next;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] vid_dist;
    logic            done;
    logic            acc_wr;
    logic            cpu_pending;
    logic            cpu_window;
    logic            vid_go;
    logic            cpu_go;

    always_ff @(posedge F14M or negedge RESET_N) begin
        if (!RESET_N) begin
            phase <= '0;
        end else if (vid_sync) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    always_ff @(posedge F14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (vid_go) begin
                    state_next = VID_RD;
                end else if (cpu_go) begin
                    state_next = CPU_ACC;
                end
            end
            VID_RD:  state_next = VID_CAP;
            VID_CAP: state_next = IDLE;
            CPU_ACC: state_next = CPU_CAP;
            CPU_CAP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // In blanking the CPU may start anywhere except the last two phases before the
    // video slot, since a 3-cycle access started there would still be busy at VID_PHASE.
    always_comb begin
        vid_dist    = phase - VID_PH;
        cpu_pending = cpu_req & ~done;
        cpu_window  = (phase == CPU_PH) | (vid_blank & (vid_dist < GUARD_FROM));
        vid_go      = (state == IDLE) & (phase == VID_PH) & vid_req;
        cpu_go      = (state == IDLE) & ~vid_go & cpu_pending & cpu_window;
        cpu_wait    = cpu_pending;
    end

    always_ff @(posedge F14M or negedge RESET_N) begin
        if (!RESET_N) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_din   <= '0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            done      <= 1'b0;
            acc_wr    <= 1'b0;
        end else begin
            vid_valid <= (state == VID_CAP);
            cpu_ack   <= (state == CPU_CAP);
            ram_we    <= cpu_go & cpu_wr;
            if (vid_go) begin
                ram_addr <= vid_addr;
            end else if (cpu_go) begin
                ram_addr <= cpu_addr;
                ram_din  <= cpu_wdata;
                acc_wr   <= cpu_wr;
            end
            if (state == VID_CAP) begin
                vid_data <= ram_dout;
            end
            if ((state == CPU_CAP) && !acc_wr) begin
                cpu_rdata <= ram_dout;
            end
            // done blocks re-service of a request still held after its ack
            if (state == CPU_CAP) begin
                done <= 1'b1;
            end else if (!cpu_req) begin
                done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed vector table, corner sequences and random scoreboard for vram_arbiter
module tb_vram_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;

    logic          F14M = 1'b0;
    logic          RESET_N = 1'b0;
    logic          vid_sync = 1'b0;
    logic          vid_blank = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_req = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;

    vram_arbiter dut (
        .F14M(F14M), .RESET_N(RESET_N), .vid_sync(vid_sync), .vid_blank(vid_blank),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 F14M = ~F14M;

    always @(posedge F14M) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic          blank, vreq;
        logic [AW-1:0] vaddr;
        logic          creq, cwr;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          we, ack, wt, vv;
        logic [DW-1:0] vdata, rdata;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tbl [40];

    function automatic vec_t mk(input int b, vr, va, cr, cw, ca, cd,
                                input int we, ack, wt, vv, vd, rd, ad);
        vec_t v;
        v.blank = 1'(b);  v.vreq = 1'(vr);  v.vaddr = AW'(va);
        v.creq  = 1'(cr); v.cwr  = 1'(cw);  v.caddr = AW'(ca); v.cwd = DW'(cd);
        v.we = 1'(we); v.ack = 1'(ack); v.wt = 1'(wt); v.vv = 1'(vv);
        v.vdata = DW'(vd); v.rdata = DW'(rd); v.addr = AW'(ad);
        return v;
    endfunction

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 'h3800) return 8'h41;
        if (i == 'h3801) return 8'h42;
        if (i == 'h0100) return 8'h5C;
        return DW'(i ^ (i >> 8));
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] set [8] = '{14'h0000, 14'h0001, 14'h1234, 14'h2000,
                                   14'h3800, 14'h3801, 14'h0100, 14'h3FFF};
        return set[$urandom_range(0, 7)];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge F14M);
        @(negedge F14M);
    endtask

    task automatic do_sync();
        vid_sync = 1'b1;
        tick();
        vid_sync = 1'b0;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int acks;
        int wes;
        int ph;
        int age;
        int gap;
        int we_cnt;
        int wr_acks;
        logic req_on;
        logic got_ack;
        logic cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        int vdue[$];
        logic [AW-1:0] vaq[$];

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end

        tbl[0]  = mk(0,1,'h3800, 0,0,0,0,         0,0,0,0,'h00,'h00,'h0000);
        tbl[1]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 0,0,1,0,'h00,'h00,'h3800);
        tbl[2]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 0,0,1,0,'h00,'h00,'h3800);
        tbl[3]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 0,0,1,1,'h41,'h00,'h3800);
        tbl[4]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 0,0,1,0,'h41,'h00,'h3800);
        tbl[5]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 1,0,1,0,'h41,'h00,'h1234);
        tbl[6]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 0,0,1,0,'h41,'h00,'h1234);
        tbl[7]  = mk(0,1,'h3800, 1,1,'h1234,'hA5, 0,1,0,0,'h41,'h00,'h1234);
        tbl[8]  = mk(0,1,'h3801, 1,1,'h1234,'hA5, 0,0,0,0,'h41,'h00,'h1234);
        tbl[9]  = mk(0,1,'h3801, 1,1,'h1234,'hA5, 0,0,0,0,'h41,'h00,'h3801);
        tbl[10] = mk(0,1,'h3801, 1,1,'h1234,'hA5, 0,0,0,0,'h41,'h00,'h3801);
        tbl[11] = mk(0,1,'h3801, 1,1,'h1234,'hA5, 0,0,0,1,'h42,'h00,'h3801);
        tbl[12] = mk(0,1,'h3801, 1,1,'h1234,'hA5, 0,0,0,0,'h42,'h00,'h3801);
        tbl[13] = mk(0,1,'h3801, 0,0,0,0,         0,0,0,0,'h42,'h00,'h3801);
        tbl[14] = mk(0,1,'h3801, 0,0,0,0,         0,0,0,0,'h42,'h00,'h3801);
        tbl[15] = mk(0,1,'h3801, 1,0,'h0100,0,    0,0,1,0,'h42,'h00,'h3801);
        tbl[16] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,0,'h42,'h00,'h3801);
        tbl[17] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,0,'h42,'h00,'h3800);
        tbl[18] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,0,'h42,'h00,'h3800);
        tbl[19] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,1,'h41,'h00,'h3800);
        tbl[20] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,0,'h41,'h00,'h3800);
        tbl[21] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,0,'h41,'h00,'h0100);
        tbl[22] = mk(0,1,'h3800, 1,0,'h0100,0,    0,0,1,0,'h41,'h00,'h0100);
        tbl[23] = mk(0,1,'h3800, 1,0,'h0100,0,    0,1,0,0,'h41,'h5C,'h0100);
        tbl[24] = mk(1,0,0,      0,0,0,0,         0,0,0,0,'h41,'h5C,'h0100);
        tbl[25] = mk(1,0,0,      0,0,0,0,         0,0,0,0,'h41,'h5C,'h0100);
        tbl[26] = mk(1,0,0,      1,0,'h1234,0,    0,0,1,0,'h41,'h5C,'h0100);
        tbl[27] = mk(1,0,0,      1,0,'h1234,0,    0,0,1,0,'h41,'h5C,'h1234);
        tbl[28] = mk(1,0,0,      1,0,'h1234,0,    0,0,1,0,'h41,'h5C,'h1234);
        tbl[29] = mk(1,0,0,      1,0,'h1234,0,    0,1,0,0,'h41,'hA5,'h1234);
        tbl[30] = mk(1,0,0,      0,0,0,0,         0,0,0,0,'h41,'hA5,'h1234);
        tbl[31] = mk(1,1,'h3800, 1,0,'h3801,0,    0,0,1,0,'h41,'hA5,'h1234);
        tbl[32] = mk(1,1,'h3800, 1,0,'h3801,0,    0,0,1,0,'h41,'hA5,'h1234);
        tbl[33] = mk(1,0,0,      1,0,'h3801,0,    0,0,1,0,'h41,'hA5,'h3800);
        tbl[34] = mk(1,0,0,      1,0,'h3801,0,    0,0,1,0,'h41,'hA5,'h3800);
        tbl[35] = mk(1,0,0,      1,0,'h3801,0,    0,0,1,1,'h41,'hA5,'h3800);
        tbl[36] = mk(1,0,0,      1,0,'h3801,0,    0,0,1,0,'h41,'hA5,'h3801);
        tbl[37] = mk(1,0,0,      1,0,'h3801,0,    0,0,1,0,'h41,'hA5,'h3801);
        tbl[38] = mk(1,0,0,      1,0,'h3801,0,    0,1,0,0,'h41,'h42,'h3801);
        tbl[39] = mk(0,0,0,      0,0,0,0,         0,0,0,0,'h41,'h42,'h3801);

        // reset state
        @(negedge F14M);
        tick();
        chk("reset ram_we", 32'(ram_we), 0);
        chk("reset ram_addr", 32'(ram_addr), 0);
        chk("reset vid_valid", 32'(vid_valid), 0);
        chk("reset cpu_ack", 32'(cpu_ack), 0);
        chk("reset cpu_rdata", 32'(cpu_rdata), 0);
        chk("reset vid_data", 32'(vid_data), 0);
        cpu_req = 1'b1;
        #1;
        chk("reset cpu_wait follows req", 32'(cpu_wait), 1);
        cpu_req = 1'b0;
        @(negedge F14M);
        RESET_N = 1'b1;
        do_sync();

        // table: one row per cycle, row index modulo 8 is the slot phase
        for (int i = 0; i < 40; i++) begin
            vid_blank = tbl[i].blank; vid_req = tbl[i].vreq; vid_addr = tbl[i].vaddr;
            cpu_req = tbl[i].creq; cpu_wr = tbl[i].cwr;
            cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            #1;
            chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(tbl[i].we));
            chk($sformatf("row%0d cpu_ack", i), 32'(cpu_ack), 32'(tbl[i].ack));
            chk($sformatf("row%0d cpu_wait", i), 32'(cpu_wait), 32'(tbl[i].wt));
            chk($sformatf("row%0d vid_valid", i), 32'(vid_valid), 32'(tbl[i].vv));
            chk($sformatf("row%0d vid_data", i), 32'(vid_data), 32'(tbl[i].vdata));
            chk($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(tbl[i].rdata));
            chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
            tick();
        end
        shadow[14'h1234] = 8'hA5;

        // reset in the middle of a CPU write
        vid_req = 1'b0; vid_blank = 1'b1; cpu_req = 1'b0;
        do_sync();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h2000; cpu_wdata = 8'h77;
        tick();
        chk("abort ram_we before reset", 32'(ram_we), 1);
        RESET_N = 1'b0;
        #1;
        chk("abort ram_we async drop", 32'(ram_we), 0);
        chk("abort no ack", 32'(cpu_ack), 0);
        tick();
        tick();
        chk("abort no ack in reset", 32'(cpu_ack), 0);
        chk("abort write not committed", 32'(mem[14'h2000] == 8'h77), 0);
        RESET_N = 1'b1;
        acks = 0; wes = 0; got_ack = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (got_ack) cpu_req = 1'b0;
            #1;
            if (ram_we) wes++;
            if (cpu_ack) begin acks++; got_ack = 1'b1; end
            tick();
        end
        chk("abort retry ack count", 32'(acks), 1);
        chk("abort retry we count", 32'(wes), 1);
        chk("abort retry data", 32'(mem[14'h2000]), 32'h77);
        shadow[14'h2000] = 8'h77;

        // vid_sync mid-frame realigns the slot
        vid_blank = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        do_sync();
        for (int c = 0; c < 5; c++) tick();
        vid_req = 1'b1; vid_addr = 14'h3801;
        do_sync();
        #1;
        chk("sync k0 vid_valid", 32'(vid_valid), 0);
        tick();
        vid_req = 1'b0;
        chk("sync k1 ram_addr", 32'(ram_addr), 32'h3801);
        tick();
        chk("sync k2 vid_valid", 32'(vid_valid), 0);
        tick();
        chk("sync k3 vid_valid", 32'(vid_valid), 1);
        chk("sync k3 vid_data", 32'(vid_data), 32'h42);

        // random CPU/video mix against a shadow memory
        do_sync();
        ph = 0; req_on = 1'b0; gap = 0; age = 0; we_cnt = 0; wr_acks = 0;
        cw = 1'b0; ca = '0; cd = '0;
        for (int c = 0; c < 10000; c++) begin
            if (ph == 0) begin
                vid_req   = ($urandom_range(0, 3) != 0);
                vid_addr  = pick_addr();
                vid_blank = ($urandom_range(0, 3) == 0);
            end
            if (gap > 0) begin
                gap--;
            end else if (!req_on && $urandom_range(0, 2) == 0) begin
                req_on = 1'b1; cw = 1'($urandom_range(0, 1));
                ca = pick_addr(); cd = DW'($urandom); age = 0;
            end
            cpu_req = req_on; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
            #1;
            if (vdue.size() > 0 && vdue[0] == c) begin
                chk("rand vid_valid due", 32'(vid_valid), 1);
                chk("rand vid_data", 32'(vid_data), 32'(shadow[vaq[0]]));
                void'(vdue.pop_front());
                void'(vaq.pop_front());
            end else begin
                chk("rand vid_valid idle", 32'(vid_valid), 0);
            end
            if (ph == 0 && vid_req) begin
                vdue.push_back(c + 3);
                vaq.push_back(vid_addr);
            end
            if (ram_we) begin
                we_cnt++;
                chk("rand we while write pending", 32'(req_on & cw), 1);
                chk("rand we addr", 32'(ram_addr), 32'(ca));
                chk("rand we data", 32'(ram_din), 32'(cd));
            end
            if (cpu_ack) begin
                chk("rand ack while pending", 32'(req_on), 1);
                chk("rand ack latency", 32'(age <= 10), 1);
                if (cw) begin
                    shadow[ca] = cd;
                    wr_acks++;
                end else begin
                    chk("rand cpu_rdata", 32'(cpu_rdata), 32'(shadow[ca]));
                end
                req_on = 1'b0;
                gap = 1;
            end else if (req_on) begin
                age++;
                if (age > 14) begin
                    chk("rand ack timeout", 32'(age), 10);
                    req_on = 1'b0;
                    gap = 1;
                end
            end
            tick();
            ph = (ph + 1) % 8;
        end
        chk("rand write pulses vs acks", 32'(we_cnt), 32'(wr_acks));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
